// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port ram port served by ram_arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;

  logic              ram_write_enable;
  logic              ram_read_enable;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_done, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_done, p1_rdata, p1_err,
    output ram_write_enable, ram_read_enable, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_done, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_done, p1_rdata, p1_err,
    input  ram_write_enable, ram_read_enable, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port ram: fetch (port 0) and LSU (port 1).
// Each access is IDLE -> ACCESS -> DONE; misaligned accesses complete with err and no ram cycle.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input logic         clk,
  input logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic              err_pending_q, err_pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic              in_access;
  logic              in_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      we_q          <= 1'b0;
      err_pending_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      we_q          <= we_d;
      err_pending_q <= err_pending_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    we_d          = we_q;
    err_pending_d = err_pending_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;

    // On a tie, round-robin favours the port that did not own the last access.
    if (bus.p0_req && bus.p1_req) begin
      win = FIXED_PRIO ? 1'b0 : ~last_owner_q;
    end else begin
      win = bus.p1_req;
    end
    win_addr = win ? bus.p1_addr : bus.p0_addr;

    unique case (state_q)
      StIdle: begin
        if (bus.p0_req || bus.p1_req) begin
          owner_d       = win;
          we_d          = win ? bus.p1_we : bus.p0_we;
          addr_d        = win_addr;
          wdata_d       = win ? bus.p1_wdata : bus.p0_wdata;
          err_pending_d = (win_addr[1:0] != 2'b00);
          state_d       = StAccess;
        end
      end
      StAccess: begin
        rdata_d = (!we_q && !err_pending_q) ? bus.ram_rdata : '0;
        state_d = StDone;
      end
      StDone: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset removes them without a clock edge.
  always_comb begin
    in_access = (state_q == StAccess);
    in_done   = (state_q == StDone);

    bus.ram_write_enable = in_access && we_q && !err_pending_q;
    bus.ram_read_enable  = in_access && !we_q && !err_pending_q;
    bus.ram_addr         = in_access ? addr_q : '0;
    bus.ram_wdata        = in_access ? wdata_q : '0;

    bus.p0_done  = in_done && !owner_q;
    bus.p1_done  = in_done && owner_q;
    bus.p0_err   = bus.p0_done && err_pending_q;
    bus.p1_err   = bus.p1_done && err_pending_q;
    bus.p0_rdata = bus.p0_done ? rdata_q : '0;
    bus.p1_rdata = bus.p1_done ? rdata_q : '0;

    bus.busy = (state_q != StIdle);
  end

endmodule
